fbuf_wr_arbiter: RTL



---
 rtl/fbuf_wr_arbiter_pkg.sv | 33 +++
 rtl/fbuf_wr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fbuf_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fbuf_wr_arbiter_pkg
// Shared colour-detect definitions used by the framebuffer write arbiter:
// framebuffer geometry defaults, pixel format width, arbiter state encoding
// and a small saturating-increment helper for the starvation counter.
// ---------------------------------------------------------------------------
package fbuf_wr_arbiter_pkg;

  // 640 x 360 framebuffer of RGB565 words
  localparam int unsigned FBUF_DEPTH_DEF  = 230400;
  localparam int unsigned FBUF_ADDR_W_DEF = 18;
  localparam int unsigned RGB565_W        = 16;

  // Starvation counter is a fixed 8-bit register; STARVE_LIMIT must fit.
  localparam int unsigned STARVE_CNT_W    = 8;

  typedef enum logic {
    ARB   = 1'b0,
    FLUSH = 1'b1
  } arb_state_e;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [STARVE_CNT_W-1:0] sat_inc(
    input logic [STARVE_CNT_W-1:0] val,
    input logic [STARVE_CNT_W-1:0] lim
  );
    if (val >= lim) begin
      return lim;
    end
    return val + 1'b1;
  endfunction

endpackage

// File: rtl/fbuf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fbuf_wr_arbiter
// Two-requester write arbiter in front of a framebuffer write port. The
// pixel stream has priority; the overlay (colour-marker) writer is
// protected from starvation by a counter that forces an overlay grant once
// it has been denied STARVE_LIMIT consecutive cycles. Accepted words are
// registered onto the framebuffer write port one cycle later; words whose
// address falls outside the framebuffer are consumed but not written and
// raise a sticky error flag.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_flush               pipeline flush, suppresses all grants while high
//   i_pix_req/addr/data   pixel-stream write request (held until ack)
//   o_pix_ack             pixel word accepted this cycle (combinational)
//   i_ovl_req/addr/data   overlay write request (held until ack)
//   o_ovl_ack             overlay word accepted this cycle (combinational)
//   o_fbuf_wr             framebuffer write strobe (registered)
//   o_fbuf_waddr/wdata    framebuffer write address/data (hold when idle)
//   o_addr_err            sticky: an accepted word was out of range
// ---------------------------------------------------------------------------
module fbuf_wr_arbiter
  import fbuf_wr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FBUF_ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH   = RGB565_W,
  parameter int unsigned FBUF_DEPTH   = FBUF_DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,

  input  logic                  i_pix_req,
  input  logic [ADDR_WIDTH-1:0] i_pix_addr,
  input  logic [DATA_WIDTH-1:0] i_pix_data,
  output logic                  o_pix_ack,

  input  logic                  i_ovl_req,
  input  logic [ADDR_WIDTH-1:0] i_ovl_addr,
  input  logic [DATA_WIDTH-1:0] i_ovl_data,
  output logic                  o_ovl_ack,

  output logic                  o_fbuf_wr,
  output logic [ADDR_WIDTH-1:0] o_fbuf_waddr,
  output logic [DATA_WIDTH-1:0] o_fbuf_wdata,
  output logic                  o_addr_err
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);
  // One extra bit so a depth of exactly 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0]     DEPTH_C = (ADDR_WIDTH+1)'(FBUF_DEPTH);

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  arb_state_e              state;
  arb_state_e              next_state;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic [STARVE_CNT_W-1:0] starve_nxt;

  logic                    pix_gnt_p0;
  logic                    ovl_gnt_p0;
  logic                    vld_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [DATA_WIDTH-1:0]   data_p0;

  logic                    vld_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]   data_p1;
  logic                    addr_err;

  // Pixel wins unless the overlay has waited its full allowance. When the
  // overlay is idle the limit cannot hold the pixel back, so a lone request
  // always moves one word per cycle.
  function automatic logic pix_wins(
    input logic                    pix_req,
    input logic                    ovl_req,
    input logic [STARVE_CNT_W-1:0] cnt
  );
    return pix_req && ((cnt < LIMIT_C) || !ovl_req);
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0: state / next-state, grant decision and starvation tracking.
  // The cycle that leaves FLUSH already arbitrates, so the only bubble seen
  // downstream after a flush is the output register stage.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ARB;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    next_state = state;
    pix_gnt_p0 = 1'b0;
    ovl_gnt_p0 = 1'b0;
    starve_nxt = starve_cnt;

    case (state)
      ARB: begin
        if (i_flush) begin
          next_state = FLUSH;
        end else begin
          pix_gnt_p0 = pix_wins(i_pix_req, i_ovl_req, starve_cnt);
          ovl_gnt_p0 = !pix_gnt_p0 && i_ovl_req;
        end
      end
      FLUSH: begin
        if (!i_flush) begin
          next_state = ARB;
          pix_gnt_p0 = pix_wins(i_pix_req, i_ovl_req, starve_cnt);
          ovl_gnt_p0 = !pix_gnt_p0 && i_ovl_req;
        end
      end
      default: begin
        next_state = ARB;
      end
    endcase

    if (i_flush || !i_ovl_req || ovl_gnt_p0) begin
      starve_nxt = '0;
    end else begin
      starve_nxt = sat_inc(starve_cnt, LIMIT_C);
    end

    // Acks are combinational; hold them low while reset is asserted.
    if (i_rst) begin
      pix_gnt_p0 = 1'b0;
      ovl_gnt_p0 = 1'b0;
    end
  end

  assign o_pix_ack = pix_gnt_p0;
  assign o_ovl_ack = ovl_gnt_p0;

  assign vld_p0  = pix_gnt_p0 || ovl_gnt_p0;
  assign addr_p0 = pix_gnt_p0 ? i_pix_addr : i_ovl_addr;
  assign data_p0 = pix_gnt_p0 ? i_pix_data : i_ovl_data;

  // -------------------------------------------------------------------------
  // Stage p1: registered framebuffer write port and sticky range error.
  // Address/data only update on a real write so they hold when idle; an
  // out-of-range word is swallowed here without disturbing them.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
      addr_err <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (vld_p0) begin
        if (addr_in_range(addr_p0)) begin
          vld_p1  <= 1'b1;
          addr_p1 <= addr_p0;
          data_p1 <= data_p0;
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

  assign o_fbuf_wr    = vld_p1;
  assign o_fbuf_waddr = addr_p1;
  assign o_fbuf_wdata = data_p1;
  assign o_addr_err   = addr_err;

endmodule
